wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Write-back end of the pipeline's register-write interface: consumes the waddr/wdata/we triple produced by the memory stage.
- Contains a MEM/WB stage register and the 32-entry general-purpose register file, committing the latched write one cycle later.
- Provides two read ports to decode, with write-through bypass from the pending write so decode never sees stale data.
- Supports pipeline stall and flush.

Parameters:
- DATA_W, 32, register/data width
- ADDR_W, 5, register address width
- NREG, 32, number of registers (must equal 2**ADDR_W)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-low (rst==0 resets on the next rising clk edge)
- stall_i  input  1  1 = hold the MEM/WB register
- flush_i  input  1  1 = load a bubble (we=0) into the MEM/WB register
- mem_waddr_i  input  ADDR_W  destination register from memory stage
- mem_wdata_i  input  DATA_W  write data from memory stage
- mem_we_i  input  1  write enable from memory stage
- re1_i  input  1  read enable, port 1
- raddr1_i  input  ADDR_W  read address, port 1
- re2_i  input  1  read enable, port 2
- raddr2_i  input  ADDR_W  read address, port 2
- rdata1_o  output  DATA_W  read data, port 1 (combinational)
- rdata2_o  output  DATA_W  read data, port 2 (combinational)
- wb_waddr_o  output  ADDR_W  latched pending write address
- wb_wdata_o  output  DATA_W  latched pending write data
- wb_we_o  output  1  latched pending write enable

Behaviour:
- **Reset.** When rst==0 at a clock edge:
  - wb_waddr_o=0, wb_wdata_o=0, wb_we_o=0.
  - All NREG array entries are cleared to 0.
  - Any pending write is dropped, not committed.
  - Reset overrides stall_i and flush_i.
- **Stage register, priority per edge:** reset > flush > stall > load.
  - flush_i=1: wb_we_o<=0, wb_waddr_o<=0, wb_wdata_o<=0. Flush wins over a simultaneous stall.
  - stall_i=1 (no flush): all three wb_* outputs hold.
  - Otherwise: wb_* <= mem_*.
- **Commit.**
  - On each non-reset edge, if wb_we_o==1 and wb_waddr_o!=0, then array[wb_waddr_o] <= wb_wdata_o.
  - Commit happens regardless of stall; re-committing a held value is idempotent.
  - Latency: a write presented on mem_* before edge E1 is latched at E1 and committed to the array at E2.
- **Register 0.** Hard-wired to zero. Writes to address 0 are ignored and never bypassed. Reads of address 0 return 0.
- **Read port k (k=1,2), combinational, evaluated in this order:**
  - rst==0 -> 0
  - re_k==0 -> 0
  - raddr_k==0 -> 0
  - wb_we_o==1 and raddr_k==wb_waddr_o -> wb_wdata_o (bypass)
  - otherwise -> array[raddr_k]
- **Port independence.** Both ports may read the same address simultaneously and return identical data.
- **Back-to-back writes to the same register.** The later write sits in the stage register and wins via bypass. The earlier write is already in the array, so there is no lost update.
- **No internal forwarding from mem_* inputs.** Forwarding from the memory stage is the responsibility of decode.
- **Widths.** No truncation or extension. Addresses ≥ NREG cannot occur because NREG = 2**ADDR_W.

Test Plan:
1. **Reset clears state.** Write 0xDEADBEEF to r5, then hold rst=0 for one edge; re1=1, raddr1=5 -> rdata1_o=0, wb_we_o=0.
2. **Basic write/commit latency.** mem_we=1, waddr=3, wdata=0x12345678 before E1.
   - After E1: wb_we_o=1, wb_waddr_o=3, and rdata1(raddr=3) returns 0x12345678 via bypass.
   - After E2 with mem_we=0: rdata1 still returns 0x12345678, now from the array.
3. **Register 0 and read enable.** Write 0xFFFFFFFF to r0, then read r0 -> 0. Read r3 (holding 0x12345678) with re2=0 -> 0.
4. **Back-to-back writes to the same register.** r7 <= 0x11 at E1, r7 <= 0x22 at E2; read r7 after E2 on both ports -> 0x22 on both. After a further idle edge -> 0x22.
5. **Stall then flush.** Load r9=0xAA with stall_i=1 active, so the latch holds its prior contents and r9 reads 0. Release the stall -> r9=0xAA after the next edge. Then present r9=0xBB with flush_i=1 -> wb_we_o=0 and r9 stays 0xAA.
6. **Reset with a write pending.** Latch r4=0x55, then assert rst=0 at the next edge -> r4 reads 0 after rst returns to 1; the pending write is lost.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB pipeline register feeding a 32-entry register file
// with two combinational read ports that bypass the pending write.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] mem_waddr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic              mem_we_i,
   input  logic              re1_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   input  logic              re2_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [DATA_W-1:0] rdata2_o,
   output logic [ADDR_W-1:0] wb_waddr_o,
   output logic [DATA_W-1:0] wb_wdata_o,
   output logic              wb_we_o
);

   logic [ADDR_W-1:0] wb_waddr_q, wb_waddr_d;
   logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
   logic              wb_we_q,    wb_we_d;
   logic [DATA_W-1:0] regs_q [NREG];

   logic commit;
   assign commit = wb_we_q && (wb_waddr_q != '0);

   // Flush beats stall: a bubble is loaded even while the stage is held.
   always_comb begin
      wb_waddr_d = wb_waddr_q;
      wb_wdata_d = wb_wdata_q;
      wb_we_d    = wb_we_q;
      if (flush_i) begin
         wb_waddr_d = '0;
         wb_wdata_d = '0;
         wb_we_d    = 1'b0;
      end else if (!stall_i) begin
         wb_waddr_d = mem_waddr_i;
         wb_wdata_d = mem_wdata_i;
         wb_we_d    = mem_we_i;
      end
   end

   // Commit ignores stall; rewriting a held entry is harmless.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_waddr_q <= '0;
         wb_wdata_q <= '0;
         wb_we_q    <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         wb_waddr_q <= wb_waddr_d;
         wb_wdata_q <= wb_wdata_d;
         wb_we_q    <= wb_we_d;
         if (commit) begin
            regs_q[wb_waddr_q] <= wb_wdata_q;
         end
      end
   end

   function automatic logic [DATA_W-1:0] rd_port(input logic              re,
                                                 input logic [ADDR_W-1:0] raddr);
      logic [DATA_W-1:0] val;
      val = '0;
      if (rst && re && (raddr != '0)) begin
         if (wb_we_q && (raddr == wb_waddr_q)) begin
            val = wb_wdata_q;
         end else begin
            val = regs_q[raddr];
         end
      end
      return val;
   endfunction

   always_comb begin
      rdata1_o = rd_port(re1_i, raddr1_i);
      rdata2_o = rd_port(re2_i, raddr2_i);
   end

   assign wb_waddr_o = wb_waddr_q;
   assign wb_wdata_o = wb_wdata_q;
   assign wb_we_o    = wb_we_q;

endmodule
